rom_read_arbiter: RTL and testbench
===================================

Name: rom_read_arbiter

Overview:
- Shares one single-port synchronous ROM (1-cycle registered read, `rom_addr` sampled at posedge, `rom_data` valid the following cycle) between two read requesters.
- Port 0 is the LCD pixel fetcher; port 1 is the CPU/bus read path.
- Arbitrates one ROM access per cycle and tracks the in-flight read.
- Returns each result to its owner through a 2-entry per-port response FIFO with valid/ready backpressure.

Parameters:
- ADDR_WIDTH, 8, ROM address width; must equal the ROM's address width.
- DATA_WIDTH, 16, ROM word width.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- p0_req_valid  in  1  port 0 read request
- p0_req_addr  in  ADDR_WIDTH  port 0 address, stable while p0_req_valid
- p0_req_ready  out  1  port 0 request accepted this cycle
- p0_rsp_valid  out  1  port 0 read data available
- p0_rsp_data  out  DATA_WIDTH  port 0 read data
- p0_rsp_ready  in  1  port 0 consumes response
- p1_req_valid, p1_req_addr, p1_req_ready, p1_rsp_valid, p1_rsp_data, p1_rsp_ready: same as port 0, for port 1
- rom_addr  out  ADDR_WIDTH  address to ROM
- rom_data  in  DATA_WIDTH  ROM read data, one cycle after address

Behaviour:
- Reset (rst_n low, asynchronous):
  - in-flight flag cleared; both FIFOs emptied.
  - p*_rsp_valid=0, p*_rsp_data=0, rom_addr=0, RR pointer favours port 0.
  - An in-flight read is discarded, not delivered after reset.
- Handshakes:
  - Request transfers when req_valid && req_ready at a posedge.
  - Response transfers when rsp_valid && rsp_ready.
  - req_valid must not depend on req_ready.
  - req_ready is combinational from valids, credits and pointer; it never asserts without req_valid.
- Credit rule: port i is eligible iff req_valid_i && (cnt_i + infl_i - pop_i) <= 1.
  - cnt_i: FIFO occupancy, 0..2.
  - infl_i: in-flight read belongs to port i.
  - pop_i: rsp_valid_i && rsp_ready_i this cycle.
  - Guarantees the FIFO never overflows and allows 1 access/cycle sustained on a single port.
- Arbitration (round-robin, default):
  - Only one eligible port: it is granted.
  - Both eligible: the port not granted most recently wins.
  - Pointer updates only on a grant.
  - At most one grant per cycle.
- ROM drive:
  - rom_addr = granted port's req_addr in a grant cycle.
  - Otherwise rom_addr holds the last issued address (held register, reset 0), so rom_data stays stable.
- Pipeline:
  - Grant at edge T sets infl=1 and infl_id=i.
  - At edge T+1, rom_data is pushed into FIFO i.
  - infl is reloaded if another grant occurs at T+1, else cleared.
- Latency: request accepted at edge T → rsp_valid high after edge T+1, i.e. 2 cycles accept-to-valid with empty FIFO.
- Ordering: responses per port in request order; no ordering between ports.
- FIFO (per port, 2 entries):
  - rsp_valid = cnt != 0; rsp_data = head entry, registered.
  - Simultaneous push and pop: count unchanged, new data goes to the tail.
  - Pop on an empty FIFO is impossible (rsp_valid=0).
  - Push when cnt=2 and no pop cannot occur by the credit rule; the bench asserts this.
- Both requesters stalled (rsp_ready low, FIFOs full): no grants, rom_addr holds, no data lost.

Optional Feature:
- Macro ROM_ARB_P0_PRIORITY_EN.
  - Defined: strict priority; port 0 wins whenever eligible; the round-robin pointer logic is removed. This guarantees LCD fetch bandwidth; port 1 may starve.
  - Undefined: round-robin as above; each port is guaranteed at least one grant in every two contended cycles.

Test Plan:
- Reset mid-read: grant p0 addr 0x10, assert rst_n low the next cycle → p0_rsp_valid stays 0 after release, rom_addr=0, no stale response delivered.
- Single port streaming: p0 requests addr 0x00..0x07 back-to-back, rsp_ready=1 → p0_req_ready high every cycle; responses = ROM[0x00..0x07] in order; first rsp_valid 2 cycles after first accept; 1 word/cycle.
- Contention RR: both valid continuously (p0 addr 0x20, p1 addr 0x40), both rsp_ready=1 → grants alternate p0,p1,p0,…; each port receives ROM[0x20] / ROM[0x40] every 2 cycles.
- Backpressure: p1 requests 0x05,0x06,0x07 with p1_rsp_ready=0 → exactly 2 accepted, p1_req_ready low thereafter; raise rsp_ready → data ROM[5], ROM[6], then 0x07 accepted and returned.
- Simultaneous push/pop at cnt=2: p0 FIFO full, p0_rsp_ready=1 with p0 request 0x30 → the grant occurs and cnt stays ≤2; output sequence has no gap or duplicate.
- ROM_ARB_P0_PRIORITY_EN defined: both valid for 4 cycles with p0 always eligible → p1_req_ready stays 0 throughout; p1 is granted the first cycle p0_req_valid drops.

Source files
------------

// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter: shares one single-port synchronous ROM between two read requesters.
//   Port 0 is the LCD pixel fetcher, port 1 the CPU/bus read path. One ROM access is
//   granted per cycle; each result returns to its owner through a 2-entry response FIFO.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   pN_req_valid/addr/ready            request handshake for port N (0 or 1)
//   pN_rsp_valid/data/ready            response handshake for port N
//   rom_addr, rom_data                 ROM address out, ROM data in (one cycle later)
// Configuration:
//   ROM_ARB_P0_PRIORITY_EN             defined: strict priority to port 0;
//                                      undefined: round-robin between the ports.
module rom_read_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_req_valid,
    input  logic [ADDR_WIDTH-1:0] p0_req_addr,
    output logic                  p0_req_ready,
    output logic                  p0_rsp_valid,
    output logic [DATA_WIDTH-1:0] p0_rsp_data,
    input  logic                  p0_rsp_ready,
    input  logic                  p1_req_valid,
    input  logic [ADDR_WIDTH-1:0] p1_req_addr,
    output logic                  p1_req_ready,
    output logic                  p1_rsp_valid,
    output logic [DATA_WIDTH-1:0] p1_rsp_data,
    input  logic                  p1_rsp_ready,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data
);
    logic [1:0]            req_v, rsp_rdy, rsp_v, pop, elig, gnt;
    logic [DATA_WIDTH-1:0] head [2];
    logic                  infl_q, infl_id_q;
    logic [ADDR_WIDTH-1:0] addr_q;

    assign req_v   = {p1_req_valid, p0_req_valid};
    assign rsp_rdy = {p1_rsp_ready, p0_rsp_ready};

    for (genvar i = 0; i < 2; i++) begin : g_port
        logic [1:0]            cnt_q;
        logic [DATA_WIDTH-1:0] e0_q, e1_q;
        logic                  push;
        // the read issued last cycle belongs to this port: its data is on rom_data now
        assign push    = infl_q && (infl_id_q == (i != 0));
        assign rsp_v[i] = cnt_q != 2'd0;
        assign pop[i]  = rsp_v[i] && rsp_rdy[i];
        // a new grant must still fit once the in-flight read lands
        assign elig[i] = req_v[i] && (({1'b0, cnt_q} + {2'b0, push} - {2'b0, pop[i]}) <= 3'd1);
        assign head[i] = e0_q;
        // e0_q is the head; e1_q only holds data while two entries are queued
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
                e0_q  <= '0;
                e1_q  <= '0;
            end else if (push && pop[i]) begin
                if (cnt_q == 2'd2) begin
                    e0_q <= e1_q;
                    e1_q <= rom_data;
                end else begin
                    e0_q <= rom_data;
                end
            end else if (pop[i]) begin
                e0_q  <= e1_q;
                cnt_q <= cnt_q - 2'd1;
            end else if (push) begin
                if (cnt_q == 2'd0) e0_q <= rom_data;
                else e1_q <= rom_data;
                cnt_q <= cnt_q + 2'd1;
            end
        end
    end

`ifdef ROM_ARB_P0_PRIORITY_EN
    assign gnt = {elig[1] && !elig[0], elig[0]};
`else
    logic ptr_q;
    // ptr_q=1 favours port 1; it points away from whichever port was granted last
    assign gnt = (&elig) ? (ptr_q ? 2'b10 : 2'b01) : elig;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= 1'b0;
        else if (|gnt) ptr_q <= gnt[0];
    end
`endif

    assign p0_req_ready = gnt[0];
    assign p1_req_ready = gnt[1];
    assign p0_rsp_valid = rsp_v[0];
    assign p1_rsp_valid = rsp_v[1];
    assign p0_rsp_data  = head[0];
    assign p1_rsp_data  = head[1];
    // holding the last address keeps rom_data stable in idle cycles
    assign rom_addr = gnt[0] ? p0_req_addr : gnt[1] ? p1_req_addr : addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            infl_q    <= 1'b0;
            infl_id_q <= 1'b0;
            addr_q    <= '0;
        end else begin
            infl_q <= |gnt;
            if (|gnt) infl_id_q <= gnt[1];
            addr_q <= rom_addr;
        end
    end
endmodule

// File: tb/tb_rom_read_arbiter.sv
// tb_rom_read_arbiter: scoreboard bench for rom_read_arbiter with a behavioural ROM.
module tb_rom_read_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        p0_req_valid = 1'b0, p0_req_ready, p0_rsp_valid, p0_rsp_ready = 1'b1;
    logic        p1_req_valid = 1'b0, p1_req_ready, p1_rsp_valid, p1_rsp_ready = 1'b1;
    logic [7:0]  p0_req_addr = '0, p1_req_addr = '0, rom_addr;
    logic [15:0] p0_rsp_data, p1_rsp_data, rom_data;
    logic [15:0] q0[$], q1[$];
    int          ac0[$], pc0[$], gl[$];
    int          total = 0, bad = 0, cyc = 0, w;

    rom_read_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_valid(p0_req_valid), .p0_req_addr(p0_req_addr), .p0_req_ready(p0_req_ready),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_data(p0_rsp_data), .p0_rsp_ready(p0_rsp_ready),
        .p1_req_valid(p1_req_valid), .p1_req_addr(p1_req_addr), .p1_req_ready(p1_req_ready),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_data(p1_rsp_data), .p1_rsp_ready(p1_rsp_ready),
        .rom_addr(rom_addr), .rom_data(rom_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [15:0] rom_f(input logic [7:0] a);
        return {a ^ 8'hA5, a + 8'h3C};
    endfunction

    always @(posedge clk) rom_data <= rom_f(rom_addr);

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h need=%0h", nm, act, exp);
        end
    endfunction

    // stimulus side: each accepted request pushes its expected data
    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
        end else begin
            if (p0_req_valid && p0_req_ready) begin
                q0.push_back(rom_f(p0_req_addr));
                ac0.push_back(cyc);
                gl.push_back(0);
            end
            if (p1_req_valid && p1_req_ready) begin
                q1.push_back(rom_f(p1_req_addr));
                gl.push_back(1);
            end
            chk("ready_rule", {29'd0, p1_req_ready && !p1_req_valid,
                               p0_req_ready && !p0_req_valid, p0_req_ready && p1_req_ready}, 32'd0);
        end
    end

    // monitor side: pop and compare on every response transfer
    always @(negedge clk) begin
        if (rst_n) begin
            if (p0_rsp_valid && p0_rsp_ready) begin
                pc0.push_back(cyc);
                if (q0.size() == 0) begin
                    total++; bad++;
                    $display("FAIL p0_rsp got=%h need=none", p0_rsp_data);
                end else chk("p0_rsp", {16'd0, p0_rsp_data}, {16'd0, q0.pop_front()});
            end
            if (p1_rsp_valid && p1_rsp_ready) begin
                if (q1.size() == 0) begin
                    total++; bad++;
                    $display("FAIL p1_rsp got=%h need=none", p1_rsp_data);
                end else chk("p1_rsp", {16'd0, p1_rsp_data}, {16'd0, q1.pop_front()});
            end
        end
    end

    // outstanding reads per port (FIFO plus in-flight) can never exceed the FIFO depth
    always @(posedge clk) if (rst_n) chk("occupancy", {31'd0, q0.size() <= 2 && q1.size() <= 2}, 32'd1);

    task automatic req(input int p, input logic [7:0] a, output int wt);
        wt = 0;
        if (p == 0) begin p0_req_valid = 1'b1; p0_req_addr = a; end
        else begin p1_req_valid = 1'b1; p1_req_addr = a; end
        @(negedge clk);
        while (!(p == 0 ? p0_req_ready : p1_req_ready) && wt < 20) begin
            wt++;
            @(negedge clk);
        end
        if (wt >= 20) begin
            total++; bad++;
            $display("FAIL req_timeout port=%0d got=no_grant need=grant", p);
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 60) begin
            @(posedge clk);
            n++;
        end
        chk("drain", {31'd0, n < 60}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout need=finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {30'd0, p1_rsp_valid, p0_rsp_valid}, 32'd0);
        chk("rst_data", {p1_rsp_data, p0_rsp_data}, 32'd0);
        chk("rst_rom_addr", {24'd0, rom_addr}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // reset while a read is in flight
        p0_req_valid = 1'b1; p0_req_addr = 8'h10;
        @(negedge clk);
        chk("t1_grant", {31'd0, p0_req_ready}, 32'd1);
        @(posedge clk); #1;
        p0_req_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t1_no_rsp", {31'd0, p0_rsp_valid}, 32'd0);
            chk("t1_rom_addr", {24'd0, rom_addr}, 32'd0);
        end
        @(posedge clk); #1;

        // single-port streaming
        ac0.delete(); pc0.delete();
        for (int i = 0; i < 8; i++) begin
            req(0, 8'(i), w);
            chk("t2_ready", w, 0);
        end
        p0_req_valid = 1'b0;
        drain();
        chk("t2_count", pc0.size(), 8);
        chk("t2_latency", pc0[0] - ac0[0], 2);
        for (int i = 1; i < 8; i++) chk("t2_rate", pc0[i] - pc0[i-1], 1);

        // contention, round-robin
        gl.delete(); pc0.delete();
        p0_req_valid = 1'b1; p0_req_addr = 8'h20;
        p1_req_valid = 1'b1; p1_req_addr = 8'h40;
        repeat (8) @(posedge clk);
        #1 p0_req_valid = 1'b0; p1_req_valid = 1'b0;
        drain();
        chk("t3_grants", gl.size(), 8);
        for (int i = 1; i < 8; i++) chk("t3_alternate", {31'd0, gl[i] != gl[i-1]}, 32'd1);
        chk("t3_p0_count", pc0.size(), 4);
        for (int i = 1; i < 4; i++) chk("t3_p0_spacing", pc0[i] - pc0[i-1], 2);

        // backpressure on port 1
        p1_rsp_ready = 1'b0;
        req(1, 8'h05, w); chk("t4_acc5", w, 0);
        req(1, 8'h06, w); chk("t4_acc6", w, 0);
        p1_req_addr = 8'h07;
        repeat (4) begin
            @(negedge clk);
            chk("t4_blocked", {31'd0, p1_req_ready}, 32'd0);
        end
        @(posedge clk); #1 p1_rsp_ready = 1'b1;
        @(negedge clk);
        chk("t4_resume", {31'd0, p1_req_ready}, 32'd1);
        @(posedge clk); #1 p1_req_valid = 1'b0;
        drain();

        // grant while the FIFO is full and popping
        p0_rsp_ready = 1'b0;
        req(0, 8'h31, w); chk("t5_acc31", w, 0);
        req(0, 8'h32, w); chk("t5_acc32", w, 0);
        p0_req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 pc0.delete(); p0_rsp_ready = 1'b1;
        req(0, 8'h30, w);
        chk("t5_grant_full", w, 0);
        p0_req_valid = 1'b0;
        drain();
        chk("t5_count", pc0.size(), 3);
        chk("t5_no_gap", pc0[2] - pc0[0], 2);

        gl.delete();
        p0_req_valid = 1'b1; p0_req_addr = 8'h50;
        p1_req_valid = 1'b1; p1_req_addr = 8'h60;
`ifdef ROM_ARB_P0_PRIORITY_EN
        repeat (4) begin
            @(negedge clk);
            chk("t6_p1_starved", {31'd0, p1_req_ready}, 32'd0);
        end
        @(posedge clk); #1 p0_req_valid = 1'b0;
        @(negedge clk);
        chk("t6_p1_granted", {31'd0, p1_req_ready}, 32'd1);
        @(posedge clk); #1 p1_req_valid = 1'b0;
`else
        repeat (4) @(posedge clk);
        #1 p0_req_valid = 1'b0; p1_req_valid = 1'b0;
        chk("t6_grants", gl.size(), 4);
        for (int i = 0; i < 4; i += 2) chk("t6_fair_pair", {31'd0, gl[i] != gl[i+1]}, 32'd1);
`endif
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
